// File: rtl/add_op.sv
// add_op: binary32 adder with round-to-nearest-even, flush-to-zero and registered result/flag.
module add_op (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] para1,
  input  logic [31:0] para2,
  output logic [31:0] out,
  output logic        under_overflow
);
  logic        sa, sb, sl, inf_a, inf_b, nan_a, nan_b, swap, eff_sub;
  logic        nan_res, both_zero, zero_dif, ovf, unf, inc, special;
  logic [7:0]  ea, eb, el, es, d;
  logic [23:0] ma, mb, ml, ms;
  logic [49:0] ext;
  logic [26:0] lg, sm, dif, nrm;
  logic [27:0] sum;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic [9:0]  e1, e2;
  logic [4:0]  lz;
  logic [31:0] d_out;
  logic        d_flag;
  assign sa = para1[31];
  assign sb = para2[31];
  assign ea = para1[30:23];
  assign eb = para2[30:23];
  assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, para1[22:0]};
  assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, para2[22:0]};
  assign inf_a = (ea == 8'hFF) && (para1[22:0] == 23'd0);
  assign inf_b = (eb == 8'hFF) && (para2[22:0] == 23'd0);
  assign nan_a = (ea == 8'hFF) && (para1[22:0] != 23'd0);
  assign nan_b = (eb == 8'hFF) && (para2[22:0] != 23'd0);
  assign swap = {eb, mb} > {ea, ma};
  assign sl = swap ? sb : sa;
  assign el = swap ? eb : ea;
  assign es = swap ? ea : eb;
  assign ml = swap ? mb : ma;
  assign ms = swap ? ma : mb;
  assign eff_sub = sa ^ sb;
  assign d = el - es;
  // Smaller significand aligned into 24 bits + guard + round, remainder folded into sticky
  assign ext = {ms, 26'd0} >> d;
  assign lg = {ml, 3'b000};
  assign sm = (d >= 8'd26) ? {26'd0, |ms} : {ext[49:24], |ext[23:0]};
  assign sum = {1'b0, lg} + {1'b0, sm};
  assign dif = lg - sm;
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (dif[i]) lz = 5'(26 - i);
  end
  assign nrm = eff_sub ? (dif << lz) : sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0];
  assign e1 = eff_sub ? {2'b00, el} - {5'd0, lz} : {2'b00, el} + {9'd0, sum[27]};
  assign inc = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
  assign rnd = {1'b0, nrm[26:3]} + {24'd0, inc};
  assign frac = rnd[24] ? rnd[23:1] : rnd[22:0];
  assign e2 = e1 + {9'd0, rnd[24]};
  // e2 is two's complement: bit 9 set means the exponent went negative
  assign ovf = !e2[9] && (e2 >= 10'd255);
  assign unf = e2[9] || (e2 == 10'd0);
  assign nan_res = nan_a | nan_b | (inf_a & inf_b & eff_sub);
  assign both_zero = (ea == 8'd0) && (eb == 8'd0);
  assign zero_dif = eff_sub && (dif == 27'd0);
  assign special = nan_res | inf_a | inf_b | both_zero | zero_dif;
  assign d_out = nan_res   ? 32'h7FC00000 :
                 inf_a     ? para1 :
                 inf_b     ? para2 :
                 both_zero ? {sa & sb, 31'd0} :
                 zero_dif  ? 32'd0 :
                 ovf       ? {sl, 8'hFF, 23'd0} :
                 unf       ? {sl, 31'd0} :
                             {sl, e2[7:0], frac};
  assign d_flag = !special && (ovf || unf);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= 32'd0;
      under_overflow <= 1'b0;
    end else begin
      out <= d_out;
      under_overflow <= d_flag;
    end
endmodule

// File: tb/tb_add_op.sv
// tb_add_op: scoreboard bench for add_op; expected {out, flag} queued at drive, popped one cycle later.
module tb_add_op;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] para1 = 32'd0;
  logic [31:0] para2 = 32'd0;
  logic [31:0] out;
  logic        under_overflow;
  logic [32:0] sb_q[$];
  int errors = 0;
  int checks = 0;

  add_op dut (.clk(clk), .rst_n(rst_n), .para1(para1), .para2(para2),
              .out(out), .under_overflow(under_overflow));

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [32:0] e;
    para1 = 32'h3F800000; para2 = 32'h3F800000;
    #2;
    checks++;
    if ({out, under_overflow} !== 33'd0) begin
      errors++; $display("FAIL reset_hold got=%h/%b want=00000000/0", out, under_overflow);
    end
    rst_n = 1'b1;
    sb_q.push_back({32'h40000000, 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if ({out, under_overflow} !== e) begin
      errors++; $display("FAIL reset_release got=%h/%b want=%h/%b", out, under_overflow, e[32:1], e[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out, under_overflow} !== 33'd0) begin
      errors++; $display("FAIL reset_async got=%h/%b want=00000000/0", out, under_overflow);
    end
    para1 = 32'h41480000; para2 = 32'h40A80000;
    @(posedge clk); #1;
    checks++;
    if ({out, under_overflow} !== 33'd0) begin
      errors++; $display("FAIL reset_discard got=%h/%b want=00000000/0", out, under_overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_same_sign();
    logic [96:0] t [3] = '{
      {32'h41480000, 32'h40A80000, 32'h418E0000, 1'b0},
      {32'h41A20000, 32'h414C0000, 32'h42040000, 1'b0},
      {32'hC1A20000, 32'hC14C0000, 32'hC2040000, 1'b0}};
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      para1 = t[i][96:65]; para2 = t[i][64:33];
      sb_q.push_back(t[i][32:0]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({out, under_overflow} !== e) begin
        errors++; $display("FAIL same_sign[%0d] got=%h/%b want=%h/%b", i, out, under_overflow, e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_mixed_sign();
    logic [96:0] t [3] = '{
      {32'h41A20000, 32'hC14C0000, 32'h40F00000, 1'b0},
      {32'hC1A20000, 32'h414C0000, 32'hC0F00000, 1'b0},
      {32'h40400000, 32'hC0400000, 32'h00000000, 1'b0}};
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      para1 = t[i][96:65]; para2 = t[i][64:33];
      sb_q.push_back(t[i][32:0]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({out, under_overflow} !== e) begin
        errors++; $display("FAIL mixed_sign[%0d] got=%h/%b want=%h/%b", i, out, under_overflow, e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [96:0] t [5] = '{
      {32'h41A7EB85, 32'h414FD70A, 32'h4207EB85, 1'b0},
      {32'h42FB147B, 32'h41C7EB85, 32'h431687AE, 1'b0},
      {32'h4504D8B4, 32'h461B13F8, 32'h463C4A25, 1'b0},
      {32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0},
      {32'h33800000, 32'h3F800000, 32'h3F800000, 1'b0}};
    logic [32:0] e;
    for (int i = 0; i < 5; i++) begin
      para1 = t[i][96:65]; para2 = t[i][64:33];
      sb_q.push_back(t[i][32:0]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({out, under_overflow} !== e) begin
        errors++; $display("FAIL rounding[%0d] got=%h/%b want=%h/%b", i, out, under_overflow, e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_limits();
    logic [96:0] t [3] = '{
      {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
      {32'h00800001, 32'h80800000, 32'h00000000, 1'b1},
      {32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1}};
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      para1 = t[i][96:65]; para2 = t[i][64:33];
      sb_q.push_back(t[i][32:0]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({out, under_overflow} !== e) begin
        errors++; $display("FAIL limits[%0d] got=%h/%b want=%h/%b", i, out, under_overflow, e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_specials();
    logic [96:0] t [6] = '{
      {32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0},
      {32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0},
      {32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0},
      {32'h3F800000, 32'h7F800000, 32'h7F800000, 1'b0},
      {32'h80000000, 32'h80000000, 32'h80000000, 1'b0},
      {32'h80000000, 32'h00000000, 32'h00000000, 1'b0}};
    logic [32:0] e;
    for (int i = 0; i < 6; i++) begin
      para1 = t[i][96:65]; para2 = t[i][64:33];
      sb_q.push_back(t[i][32:0]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({out, under_overflow} !== e) begin
        errors++; $display("FAIL specials[%0d] got=%h/%b want=%h/%b", i, out, under_overflow, e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [32:0] e;
    para1 = 32'h41480000; para2 = 32'h40A80000;
    sb_q.push_back({32'h418E0000, 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    para1 = 32'h7F7FFFFF; para2 = 32'h7F7FFFFF;
    #2;
    checks++;
    if ({out, under_overflow} !== e) begin
      errors++; $display("FAIL hold got=%h/%b want=%h/%b", out, under_overflow, e[32:1], e[0]);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_same_sign();
    test_mixed_sign();
    test_rounding();
    test_limits();
    test_specials();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_op.md
# add_op

Single-precision IEEE-754 floating-point adder, the addition unit of the floating-point ALU. Adds two 32-bit binary32 operands with sign handling (so it also performs subtraction of mixed-sign operands), rounds to nearest-even, and flags exponent overflow or underflow. Operands are accepted every cycle. The result and flag are registered, giving one cycle of latency.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- para1  in  32  operand A, binary32: sign [31], exponent [30:23], fraction [22:0].
- para2  in  32  operand B, binary32.
- out  out  32  registered sum A+B, binary32.
- under_overflow  out  1  registered flag: result exponent overflowed or underflowed.

## Operation
- Unpack each operand: sign, 8-bit biased exponent, 24-bit significand with the hidden 1.
- Exponent 0 (zero or denormal): the operand is treated as ±0 (flush-to-zero).
- Swap the operands so A has the larger magnitude: compare the exponent first, then the significand.
- Alignment:
  - Right-shift the smaller significand by the exponent difference.
  - Keep guard, round and sticky bits.
  - Difference ≥ 26: the smaller operand contributes only to sticky.
- Same signs: add the significands. On carry-out, shift right by 1 (the shifted-out bit joins guard/sticky) and increment the exponent.
- Different signs: subtract the smaller from the larger. Left-normalize using a leading-zero count and decrement the exponent by the shift amount.
- Result sign = sign of the larger-magnitude operand.
- Exact zero difference (x + (−x)) → +0 (0x00000000), flag 0.
- Rounding is round-to-nearest-even:
  - Increment when guard=1 and (round|sticky|LSB)=1.
  - A rounding carry-out renormalizes: shift right 1 and increment the exponent.
- Overflow (final biased exponent ≥ 255): out = sign,0xFF,0 (±Inf), flag = 1.
- Underflow (nonzero result with final biased exponent ≤ 0): out = signed zero, flag = 1.
- Special inputs:
  - Either operand NaN (exp 0xFF, fraction ≠ 0) → out = 0x7FC00000, flag 0.
  - +Inf + −Inf → 0x7FC00000, flag 0.
  - Otherwise any Inf operand → that Inf, flag 0.
- Both operands zero → +0, except (−0)+(−0) → 0x80000000. Flag 0.
- All other cases: flag 0.

## Timing
- Datapath is combinational from para1/para2 to D of the out/under_overflow registers. It is fully pipelined: one new operand pair per cycle.
- Latency: operands present before rising edge N appear on out/under_overflow after edge N (one cycle).
- No handshake; every cycle is valid.
- Reset: asynchronous assertion (rst_n=0) immediately forces out=0x00000000 and under_overflow=0.
- Reset release takes effect at the next rising edge, which captures the current inputs.
- Reset asserted mid-stream discards the pending result; there is no other state.
- Operand changes between edges have no effect on the outputs until the next edge.

## Test plan
- Reset: drive rst_n=0 with arbitrary operands → out=0x00000000, under_overflow=0 without a clock edge. Release → the first result appears after the next edge.
- Same-sign add, streamed back-to-back one per cycle; each result one cycle later, flag 0:
  - 0x41480000 + 0x40A80000 (12.5+5.25) → 0x418E0000.
  - 0x41A20000 + 0x414C0000 (20.25+12.75) → 0x42040000.
  - 0xC1A20000 + 0xC14C0000 → 0xC2040000.
- Mixed sign, flag 0:
  - 0x41A20000 + 0xC14C0000 → 0x40F00000 (7.5).
  - 0xC1A20000 + 0x414C0000 → 0xC0F00000 (−7.5).
  - 0x40400000 + 0xC0400000 → 0x00000000.
- Alignment and rounding, flag 0:
  - 0x41A7EB85 + 0x414FD70A → 0x4207EB85.
  - 0x42FB147B + 0x41C7EB85 → 0x431687AE.
  - 0x4504D8B4 + 0x461B13F8 → 0x463C4A25.
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000 (round to even).
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flag 1.
- Underflow: 0x00800001 + 0x80800000 → 0x00000000, flag 1.
- Specials:
  - 0x7FC00000 + 0x3F800000 → 0x7FC00000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0xFF800000 + 0x3F800000 → 0xFF800000.
  - All with flag 0.
